fpnew_rounding_pipe: RTL
========================

// Module: fpnew_rounding_pipe
// PURPOSE
// - Multi-lane, pipelined IEEE-754 rounding stage for vectorised FP units (SIMD casts/FMA back-ends).
// - Reduces a wide field of discarded bits to round/sticky, applies RNE/RTZ/RDN/RUP/RMM/ROD per lane, and flags inexact and carry-out.
// - Elastic valid/ready pipeline with a pass-through tag and synchronous flush; sits between the normaliser and the result packer.
// PARAMETERS
// - AbsWidth     32  width of each lane's magnitude (no sign bit), >=2
// - DiscWidth    8   discarded bits per lane, MSB = round bit, rest = sticky source, >=2
// - NumLanes     2   independent lanes sharing one handshake, >=1
// - NumPipeRegs  1   register stages after the rounding logic, 0 = combinational
// - TagWidth     4   opaque tag carried alongside each beat
// PORTS
// - clk_i           in   1                    clock, rising edge
// - rst_i           in   1                    asynchronous reset, active-high
// - flush_i         in   1                    synchronous kill of all in-flight beats
// - in_valid_i      in   1                    input beat valid
// - in_ready_o      out  1                    input beat accepted when in_valid_i & in_ready_o
// - abs_value_i     in   NumLanes*AbsWidth    per-lane magnitude, lane k at [k*AbsWidth +: AbsWidth]
// - sign_i          in   NumLanes             per-lane sign
// - disc_bits_i     in   NumLanes*DiscWidth   per-lane bits shifted out below the LSB
// - eff_sub_i       in   NumLanes             per-lane effective subtraction (zero-sign rule)
// - lane_mask_i     in   NumLanes             1 = lane active
// - rnd_mode_i      in   fpnew_pkg::roundmode_e  rounding mode, shared by all lanes of a beat
// - tag_i           in   TagWidth             beat tag
// - out_valid_o     out  1                    output beat valid
// - out_ready_i     in   1                    downstream accepts
// - abs_rounded_o   out  NumLanes*AbsWidth    rounded magnitude, modulo 2^AbsWidth
// - sign_o          out  NumLanes             result sign
// - exact_zero_o    out  NumLanes             magnitude==0 and all disc bits==0
// - inexact_o       out  NumLanes             any disc bit set
// - carry_o         out  NumLanes             rounding incremented an all-ones magnitude
// - tag_o           out  TagWidth             tag of the output beat
// - busy_o          out  1                    any stage holds a valid beat
// BEHAVIOUR
// - Per lane: R = disc[DiscWidth-1], S = |disc[DiscWidth-2:0]; round_up:
//   RNE: R&(S|abs[0]); RTZ: 0; RDN: (R|S)&sign; RUP: (R|S)&~sign; RMM: R; ROD: 0 but result LSB forced to 1 when R|S.
//   Any other encoding: round_up=0, no LSB forcing (deterministic, never X).
// - abs_rounded = abs + round_up (AbsWidth bits, wraps); carry = round_up & (abs=='1).
// - sign: if exact_zero & eff_sub -> (rnd_mode==RDN), else sign_i.
// - Masked lane (lane_mask=0): abs_rounded/sign/exact_zero/inexact/carry all 0 at the output.
// - Pipeline: rounding logic is combinational on the input; NumPipeRegs stages follow. Latency = NumPipeRegs cycles from accept to out_valid_o.
// - Stage s loads when its valid is 0 or stage s+1 (or output) is taking its beat; in_ready_o = stage-0 ready. Full throughput (1 beat/cycle) under continuous out_ready_i.
// - Stall: out_valid_o=1 & out_ready_i=0 holds all output fields stable; no beat dropped or duplicated.
// - NumPipeRegs=0: out_valid_o=in_valid_i, in_ready_o=out_ready_i, outputs combinational.
// - flush_i: all stage valids cleared at the next edge; an input presented in the flush cycle is dropped; in_ready_o unaffected. Flush wins over a simultaneous accept.
// - Reset (any time, incl. mid-beat): all valids 0, all data/tag registers 0; out_valid_o=0, busy_o=0, all data outputs 0 (NumPipeRegs>0). in_ready_o=1 after reset.
// - Only valid bits need reset for correctness; data registers are still reset for deterministic outputs.
// - Data registers enable only on load; no toggling while empty.
// STRUCTURE
// - fpnew_pkg: roundmode_e gains ROD (3'b101); add struct round_lane_res_t {abs, sign, exact_zero, inexact, carry}.
// - Sub-module fpnew_round_lane: combinational single-lane decision and increment, instantiated NumLanes times.
// - Top holds the generic elastic register chain (generate loop over NumPipeRegs), tag, and flush/reset logic.
// TESTING
// - AbsWidth=4, RNE, abs=4'b0101, disc=8'h80 -> abs_rounded=4'b0110, inexact=1; abs=4'b0100, disc=8'h80 -> 4'b0100.
// - RDN, sign=1, abs=4'hF, disc=8'h01 -> abs_rounded=4'h0, carry=1, inexact=1; same with RUP -> 4'hF, carry=0.
// - ROD, abs=4'b0110, disc=8'h40 -> 4'b0111; disc=8'h00 -> 4'b0110, inexact=0.
// - abs=0, disc=0, eff_sub=1, sign=0: RDN -> sign_o=1, exact_zero=1; RNE -> sign_o=0.
// - NumPipeRegs=2: 8 back-to-back beats, out_ready_i low on cycles 3-5 -> all 8 emerge in order, tags 0..7, stalled outputs stable, latency 2.
// - Flush with 2 beats in flight plus new input, then reset mid-stream -> no output beat appears; busy_o=0 next cycle; out_valid_o=0 during reset.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Shared types for the FP rounding back-end: rounding modes and the per-lane flag bundle.
package fpnew_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101
  } roundmode_e;

  // The rounded magnitude travels beside this struct because its width is a module parameter.
  typedef struct packed {
    logic sign;
    logic exact_zero;
    logic inexact;
    logic carry;
  } round_lane_res_t;

endpackage

// File: rtl/fpnew_round_lane.sv
// Single-lane rounding decision and increment; purely combinational.
module fpnew_round_lane
  import fpnew_pkg::*;
#(
  parameter int unsigned AbsWidth  = 32,
  parameter int unsigned DiscWidth = 8
) (
  input  logic [AbsWidth-1:0]  abs_i,
  input  logic                 sign_i,
  input  logic [DiscWidth-1:0] disc_i,
  input  logic                 eff_sub_i,
  input  logic                 lane_en_i,
  input  roundmode_e           rnd_mode_i,
  output logic [AbsWidth-1:0]  abs_o,
  output round_lane_res_t      res_o
);

  logic                round_bit;
  logic                sticky;
  logic                round_up;
  logic                force_lsb;
  logic                exact_zero;
  logic                res_sign;
  logic [AbsWidth-1:0] sum;

  // Unknown mode encodings fall through to truncation so the result is never X.
  always_comb begin
    round_bit = disc_i[DiscWidth-1];
    sticky    = |disc_i[DiscWidth-2:0];
    round_up  = 1'b0;
    force_lsb = 1'b0;
    case (rnd_mode_i)
      RNE:     round_up = round_bit & (sticky | abs_i[0]);
      RTZ:     round_up = 1'b0;
      RDN:     round_up = (round_bit | sticky) & sign_i;
      RUP:     round_up = (round_bit | sticky) & ~sign_i;
      RMM:     round_up = round_bit;
      ROD:     force_lsb = round_bit | sticky;
      default: round_up = 1'b0;
    endcase

    sum = abs_i + {{(AbsWidth-1){1'b0}}, round_up};
    if (force_lsb) sum[0] = 1'b1;

    exact_zero = ~(|abs_i) & ~(round_bit | sticky);
    res_sign   = (exact_zero & eff_sub_i) ? (rnd_mode_i == RDN) : sign_i;

    abs_o            = lane_en_i ? sum : '0;
    res_o.sign       = lane_en_i & res_sign;
    res_o.exact_zero = lane_en_i & exact_zero;
    res_o.inexact    = lane_en_i & (round_bit | sticky);
    res_o.carry      = lane_en_i & round_up & (&abs_i);
  end

endmodule

// File: rtl/fpnew_rounding_pipe.sv
// Multi-lane rounding stage followed by an elastic valid/ready register chain with tag and flush.
module fpnew_rounding_pipe
  import fpnew_pkg::*;
#(
  parameter int unsigned AbsWidth    = 32,
  parameter int unsigned DiscWidth   = 8,
  parameter int unsigned NumLanes    = 2,
  parameter int unsigned NumPipeRegs = 1,
  parameter int unsigned TagWidth    = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [NumLanes*AbsWidth-1:0]  abs_value_i,
  input  logic [NumLanes-1:0]           sign_i,
  input  logic [NumLanes*DiscWidth-1:0] disc_bits_i,
  input  logic [NumLanes-1:0]           eff_sub_i,
  input  logic [NumLanes-1:0]           lane_mask_i,
  input  fpnew_pkg::roundmode_e         rnd_mode_i,
  input  logic [TagWidth-1:0]           tag_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [NumLanes*AbsWidth-1:0]  abs_rounded_o,
  output logic [NumLanes-1:0]           sign_o,
  output logic [NumLanes-1:0]           exact_zero_o,
  output logic [NumLanes-1:0]           inexact_o,
  output logic [NumLanes-1:0]           carry_o,
  output logic [TagWidth-1:0]           tag_o,
  output logic                          busy_o
);

  localparam int unsigned DataWidth = NumLanes * (AbsWidth + 4) + TagWidth;

  logic [NumLanes*AbsWidth-1:0] rnd_abs;
  logic [NumLanes-1:0]          rnd_sign;
  logic [NumLanes-1:0]          rnd_zero;
  logic [NumLanes-1:0]          rnd_inexact;
  logic [NumLanes-1:0]          rnd_carry;

  for (genvar k = 0; k < NumLanes; k++) begin : gen_lane
    round_lane_res_t lane_res;

    fpnew_round_lane #(
      .AbsWidth  (AbsWidth),
      .DiscWidth (DiscWidth)
    ) i_round_lane (
      .abs_i      (abs_value_i[k*AbsWidth +: AbsWidth]),
      .sign_i     (sign_i[k]),
      .disc_i     (disc_bits_i[k*DiscWidth +: DiscWidth]),
      .eff_sub_i  (eff_sub_i[k]),
      .lane_en_i  (lane_mask_i[k]),
      .rnd_mode_i (rnd_mode_i),
      .abs_o      (rnd_abs[k*AbsWidth +: AbsWidth]),
      .res_o      (lane_res)
    );

    assign rnd_sign[k]    = lane_res.sign;
    assign rnd_zero[k]    = lane_res.exact_zero;
    assign rnd_inexact[k] = lane_res.inexact;
    assign rnd_carry[k]   = lane_res.carry;
  end

  // Index 0 is the combinational rounding result; 1..NumPipeRegs are registers.
  logic [DataWidth-1:0] stage_data  [NumPipeRegs+1];
  logic                 stage_valid [NumPipeRegs+1];
  logic                 stage_ready [NumPipeRegs+1];

  assign stage_data[0]  = {tag_i, rnd_carry, rnd_inexact, rnd_zero, rnd_sign, rnd_abs};
  assign stage_valid[0] = in_valid_i;
  assign stage_ready[NumPipeRegs] = out_ready_i;

  for (genvar s = 0; s < NumPipeRegs; s++) begin : gen_stage
    logic                 valid_q;
    logic [DataWidth-1:0] data_q;

    assign stage_ready[s]   = ~valid_q | stage_ready[s+1];
    assign stage_valid[s+1] = valid_q;
    assign stage_data[s+1]  = data_q;

    // Flush overrides any load; data only moves when a valid beat is actually taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        if (flush_i) begin
          valid_q <= 1'b0;
        end else if (stage_ready[s]) begin
          valid_q <= stage_valid[s];
        end
        if (stage_ready[s] && stage_valid[s]) begin
          data_q <= stage_data[s];
        end
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int s = 1; s <= NumPipeRegs; s++) begin
      busy_o = busy_o | stage_valid[s];
    end
  end

  assign in_ready_o  = stage_ready[0];
  assign out_valid_o = stage_valid[NumPipeRegs];
  assign {tag_o, carry_o, inexact_o, exact_zero_o, sign_o, abs_rounded_o} = stage_data[NumPipeRegs];

endmodule
